uart_rx_param: RTL

Parametrised UART receiver, the successor of the fixed 8N1 receiver used by the VGA text controller (column/row/char byte stream).
- Adds configurable baud/clock ratio, data width and parity.
- Majority-vote oversampling, and framing, parity and overrun error reporting.
- Output FIFO with a valid/ready handshake, so the consumer (char-write FSM) may stall.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_fifo.sv | 52 +++++
 rtl/uart_rx_param.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM encoding, parity
// modes, majority vote and baud divider helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

   // Rounded clock cycles per oversample tick.
   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      int den;
      den = baud * oversample;
      return (clk_freq + den / 2) / den;
   endfunction

   function automatic logic expected_parity(input logic data_xor, input int mode);
      case (mode)
         PARITY_EVEN: return data_xor;
         PARITY_ODD:  return ~data_xor;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with first-word visibility; shared by the UART RX and TX paths.
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW + 1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop frees a slot in the same cycle, so push-while-full succeeds then.
   assign do_push = push && (!full || do_pop);

   assign pop_data = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with error pulses and output FIFO.
// Define UART_RX_BREAK_EN to add the break_o line-break detector.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 25000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 8,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 uart_rx_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
`ifdef UART_RX_BREAK_EN
   output logic                 break_o,
`endif
   output logic                 frame_err_o,
   output logic                 parity_err_o,
   output logic                 overrun_o
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int CW  = $clog2(DATA_BITS);
   localparam int MID = OVERSAMPLE / 2;

   rx_state_t            state_reg, state_next;
   logic [1:0]           sync_reg;
   logic                 rx;
   logic                 rx_prev_reg;
   logic [TW-1:0]        tick_cnt_reg;
   logic [SW-1:0]        samp_cnt_reg;
   logic                 tick;
   logic [2:0]           samp_reg;
   logic                 decide_reg;
   logic                 bit_val;
   logic [DATA_BITS-1:0] shift_reg;
   logic [CW-1:0]        bit_cnt_reg;
   logic                 par_bad_reg;
   logic                 brk;
   logic                 start_det, shift_en, par_chk_en, push;
   logic                 frame_err_next, parity_err_next, overrun_next;
   logic                 pop, fifo_full, fifo_empty;

   assign rx      = sync_reg[1];
   assign tick    = (tick_cnt_reg == TW'(DIV - 1));
   assign bit_val = majority3(samp_reg);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_reg    <= 2'b11;
         rx_prev_reg <= 1'b1;
      end else begin
         sync_reg    <= {sync_reg[0], uart_rx_i};
         rx_prev_reg <= rx;
      end
   end

   // Sample index k of a bit falls k ticks after its leading edge.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         tick_cnt_reg <= '0;
         samp_cnt_reg <= '0;
         decide_reg   <= 1'b0;
      end else if (start_det) begin
         tick_cnt_reg <= '0;
         samp_cnt_reg <= SW'(1);
         decide_reg   <= 1'b0;
      end else begin
         decide_reg <= tick && (samp_cnt_reg == SW'(MID + 1));
         if (tick) begin
            tick_cnt_reg <= '0;
            samp_cnt_reg <= (samp_cnt_reg == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt_reg + 1'b1;
         end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_samp
      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i)
            samp_reg[gi] <= 1'b1;
         else if (tick && samp_cnt_reg == SW'(MID - 1 + gi))
            samp_reg[gi] <= rx;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_reg <= ST_IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next      = state_reg;
      start_det       = 1'b0;
      shift_en        = 1'b0;
      par_chk_en      = 1'b0;
      push            = 1'b0;
      frame_err_next  = 1'b0;
      parity_err_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (rx_prev_reg && !rx && !brk) begin
               start_det  = 1'b1;
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (decide_reg) state_next = bit_val ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (decide_reg) begin
               shift_en = 1'b1;
               if (bit_cnt_reg == CW'(DATA_BITS - 1))
                  state_next = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (decide_reg) begin
               par_chk_en = 1'b1;
               state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            if (decide_reg) begin
               state_next = ST_IDLE;
               if (!bit_val)        frame_err_next  = 1'b1;
               else if (par_bad_reg) parity_err_next = 1'b1;
               else                 push            = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         par_bad_reg <= 1'b0;
      end else if (start_det) begin
         bit_cnt_reg <= '0;
         par_bad_reg <= 1'b0;
      end else begin
         if (shift_en) begin
            shift_reg   <= {bit_val, shift_reg[DATA_BITS-1:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
         end
         if (par_chk_en)
            par_bad_reg <= (bit_val != expected_parity(^shift_reg, PARITY));
      end
   end

   assign pop          = valid_o && ready_i;
   assign valid_o      = !fifo_empty;
   assign overrun_next = push && fifo_full && !pop;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         frame_err_o  <= 1'b0;
         parity_err_o <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         frame_err_o  <= frame_err_next;
         parity_err_o <= parity_err_next;
         overrun_o    <= overrun_next;
      end
   end

   uart_rx_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(DATA_BITS)
   ) u_fifo (
      .clk      (clk_i),
      .rst_n    (rstn_i),
      .push     (push),
      .push_data(shift_reg),
      .pop      (pop),
      .pop_data (data_o),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

`ifdef UART_RX_BREAK_EN
   localparam int FRAME_BITS = 2 + DATA_BITS + ((PARITY == PARITY_NONE) ? 0 : 1);
   localparam int BRK_TICKS  = 2 * FRAME_BITS * OVERSAMPLE;
   localparam int BW         = $clog2(BRK_TICKS + 1);

   logic [BW-1:0] brk_cnt_reg;
   logic          brk_reg;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         brk_cnt_reg <= '0;
         brk_reg     <= 1'b0;
      end else if (rx) begin
         brk_cnt_reg <= '0;
         brk_reg     <= 1'b0;
      end else if (tick && !brk_reg) begin
         brk_cnt_reg <= brk_cnt_reg + 1'b1;
         if (brk_cnt_reg == BW'(BRK_TICKS - 1)) brk_reg <= 1'b1;
      end
   end

   assign brk     = brk_reg;
   assign break_o = brk_reg;
`else
   assign brk = 1'b0;
`endif

endmodule
